// File: rtl/memory_dumper_if.sv
// rtl/memory_dumper_if.sv - command, RAM read port and serial line of the memory dumper
interface memory_dumper_if;
   logic        start;
   logic [15:0] start_addr;
   logic [15:0] word_count;
   logic [15:0] ram_address;
   logic        ram_read_en;
   logic [15:0] ram_data_in;
   logic        rs232_tx;
   logic        busy;
   logic        done;

   modport slave (
      input  start, start_addr, word_count, ram_data_in,
      output ram_address, ram_read_en, rs232_tx, busy, done
   );

   modport master (
      output start, start_addr, word_count, ram_data_in,
      input  ram_address, ram_read_en, rs232_tx, busy, done
   );
endinterface

// File: rtl/memory_dumper.sv
// rtl/memory_dumper.sv - reads a block of RAM words and streams them out as 8N1 bytes
// Each word goes out low byte first; the serial line is driven idle-high outside TX states.
module memory_dumper #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int RD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   memory_dumper_if.slave   dump_if
);
   localparam int BAUD_DIV = CLK_HZ / BAUD;
   localparam int CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, TX_LO, TX_HI, FIN
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    addr_q, addr_d;
   logic [15:0]    rem_q, rem_d;
   logic [15:0]    word_q, word_d;
   logic [15:0]    ram_addr_q, ram_addr_d;
   logic [CW-1:0]  baud_q, baud_d;
   logic [3:0]     bit_q, bit_d;
   logic [LW-1:0]  lat_q, lat_d;
   logic           busy_q, busy_d;

   logic [7:0]     tx_byte;
   logic [2:0]     data_idx;
   logic           tx_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         word_q     <= '0;
         ram_addr_q <= '0;
         baud_q     <= '0;
         bit_q      <= '0;
         lat_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         word_q     <= word_d;
         ram_addr_q <= ram_addr_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         lat_q      <= lat_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      word_d     = word_q;
      ram_addr_d = ram_addr_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      lat_d      = lat_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            if (dump_if.start) begin
               addr_d  = dump_if.start_addr;
               rem_d   = dump_if.word_count;
               busy_d  = 1'b1;
               state_d = (dump_if.word_count != 16'd0) ? RD_REQ : FIN;
            end
         end
         RD_REQ: begin
            ram_addr_d = addr_q;
            lat_d      = '0;
            state_d    = RD_WAIT;
         end
         RD_WAIT: begin
            // last wait cycle is exactly RD_LAT cycles after the strobe
            if (lat_q == LW'(RD_LAT - 1)) begin
               word_d  = dump_if.ram_data_in;
               baud_d  = '0;
               bit_d   = '0;
               state_d = TX_LO;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         TX_LO, TX_HI: begin
            if (baud_q == CW'(BAUD_DIV - 1)) begin
               baud_d = '0;
               if (bit_q == 4'd9) begin
                  bit_d = '0;
                  if (state_q == TX_LO) begin
                     state_d = TX_HI;
                  end else begin
                     addr_d  = addr_q + 16'd1;
                     rem_d   = rem_q - 16'd1;
                     state_d = (rem_q == 16'd1) ? FIN : RD_REQ;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // frame slot 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit
   always_comb begin
      tx_byte  = (state_q == TX_HI) ? word_q[15:8] : word_q[7:0];
      data_idx = 3'(bit_q - 4'd1);
      tx_bit   = 1'b1;
      if (state_q == TX_LO || state_q == TX_HI) begin
         if (bit_q == 4'd0) begin
            tx_bit = 1'b0;
         end else if (bit_q != 4'd9) begin
            tx_bit = tx_byte[data_idx];
         end
      end
   end

   assign dump_if.ram_read_en = (state_q == RD_REQ);
   assign dump_if.ram_address = (state_q == RD_REQ) ? addr_q : ram_addr_q;
   assign dump_if.rs232_tx    = tx_bit;
   assign dump_if.busy        = busy_q;
   assign dump_if.done        = (state_q == FIN);
endmodule
